regfile_wb_writer: RTL and testbench

- Write-side master for the register file's single write port (regWriteEnable/addrD/dataD), owned by the writeback stage.
- Merges two writeback sources:
  - Single-cycle ALU results, which have priority.
  - A small FIFO of results from multi-cycle units (load, mul/div), drained into idle write-port cycles.
- Provides forwarding lookup and WAW squash so a buffered result never overwrites a younger ALU result.

---
 rtl/regfile_wb_writer.sv | 198 +++++++++++++++++++
 tb/tb_regfile_wb_writer.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_writer.sv
// regfile_wb_writer
//   Write-side master for the register file's single write port, owned by the
//   writeback stage. Single-cycle ALU results always win the port; results
//   from multi-cycle units (load, mul/div) wait in a small FIFO and drain into
//   idle write-port cycles. An ALU write clears the valid bit of every buffered
//   entry with the same destination (WAW squash), so an older buffered result
//   can never overwrite a younger ALU result.
//
//   Optional feature: define REGWB_FWD_EN to build the forwarding compare/mux.
//   Without it fwdHitA/B and fwdDataA/B are tied to 0 (ports remain).
//
// Ports
//   clock, clear                      clock, asynchronous active-high reset
//   aluWbEnable/aluWbAddr/aluWbData   ALU result to write this cycle
//   pushValid/pushReady/pushAddr/pushData
//                                     multi-cycle result handshake into FIFO
//   regWriteEnable/addrD/dataD        registered register-file write port
//   lookupA/B, fwdHitA/B, fwdDataA/B  combinational forwarding queries
//   count/empty/full                  FIFO occupancy (squashed entries count)

module regfile_wb_writer #(
    parameter int width     = 32,
    parameter int addrWidth = 5,
    parameter int depth     = 4
) (
    input  logic                         clock,
    input  logic                         clear,
    input  logic                         aluWbEnable,
    input  logic [addrWidth-1:0]         aluWbAddr,
    input  logic [width-1:0]             aluWbData,
    input  logic                         pushValid,
    output logic                         pushReady,
    input  logic [addrWidth-1:0]         pushAddr,
    input  logic [width-1:0]             pushData,
    output logic                         regWriteEnable,
    output logic [addrWidth-1:0]         addrD,
    output logic [width-1:0]             dataD,
    input  logic [addrWidth-1:0]         lookupA,
    input  logic [addrWidth-1:0]         lookupB,
    output logic                         fwdHitA,
    output logic                         fwdHitB,
    output logic [width-1:0]             fwdDataA,
    output logic [width-1:0]             fwdDataB,
    output logic [$clog2(depth+1)-1:0]   count,
    output logic                         empty,
    output logic                         full
);

    localparam int PW = $clog2(depth);
    localparam int CW = $clog2(depth+1);

    logic [addrWidth-1:0] addr_mem [depth];
    logic [width-1:0]     data_mem [depth];

    logic [depth-1:0]     valid_q, valid_d;
    logic [PW-1:0]        head_q, head_d;
    logic [PW-1:0]        tail_q, tail_d;
    logic [CW-1:0]        count_q, count_d;
    logic                 wen_q, wen_d;
    logic [addrWidth-1:0] out_addr_q, out_addr_d;
    logic [width-1:0]     out_data_q, out_data_d;

    logic alu_take, push_fire, push_store;
    logic head_exists, head_valid, pop, head_write;

    // Ready looks only at registered occupancy: a full buffer refuses a push
    // even when the head pops in the same cycle.
    assign full      = (count_q == CW'(depth));
    assign empty     = (count_q == '0);
    assign count     = count_q;
    assign pushReady = !full && !clear;

    // NOTE: every variable driven in an always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        alu_take    = aluWbEnable && (aluWbAddr != '0);
        push_fire   = pushValid && pushReady;
        // A push to x0 completes the handshake but stores nothing.
        push_store  = push_fire && (pushAddr != '0);
        head_exists = (count_q != '0);
        head_valid  = valid_q[head_q];
        // A squashed head is discarded even while the ALU owns the port.
        pop         = head_exists && (!head_valid || !alu_take);
        head_write  = head_exists && head_valid && !alu_take;

        head_d  = pop ? head_q + PW'(1) : head_q;
        tail_d  = push_store ? tail_q + PW'(1) : tail_q;
        count_d = count_q + CW'(push_store) - CW'(pop);

        valid_d = valid_q;
        for (int i = 0; i < depth; i++) begin
            if (pop && (PW'(i) == head_q))
                valid_d[i] = 1'b0;
            if (push_store && (PW'(i) == tail_q))
                valid_d[i] = 1'b1;
            // WAW squash also catches the entry being pushed this very cycle.
            if (alu_take &&
                (((push_store && (PW'(i) == tail_q)) ? pushAddr : addr_mem[i]) == aluWbAddr))
                valid_d[i] = 1'b0;
        end

        wen_d      = 1'b0;
        out_addr_d = out_addr_q;
        out_data_d = out_data_q;
        if (alu_take) begin
            wen_d      = 1'b1;
            out_addr_d = aluWbAddr;
            out_data_d = aluWbData;
        end else if (head_write) begin
            wen_d      = 1'b1;
            out_addr_d = addr_mem[head_q];
            out_data_d = data_mem[head_q];
        end
    end

    // NOTE: sequential state is updated with non-blocking assignments so all
    // registers sample their next-state values from the same pre-edge snapshot.
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            valid_q    <= '0;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            wen_q      <= 1'b0;
            out_addr_q <= '0;
            out_data_q <= '0;
        end else begin
            valid_q    <= valid_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            wen_q      <= wen_d;
            out_addr_q <= out_addr_d;
            out_data_q <= out_data_d;
        end
    end

    // NOTE: payload storage has no reset; the valid bits and count alone decide
    // whether an entry is used, so stale contents are never observed.
    always_ff @(posedge clock) begin
        if (push_store) begin
            addr_mem[tail_q] <= pushAddr;
            data_mem[tail_q] <= pushData;
        end
    end

    assign regWriteEnable = wen_q;
    assign addrD          = out_addr_q;
    assign dataD          = out_data_q;

`ifdef REGWB_FWD_EN
    // Scan oldest to youngest so the youngest matching candidate ends up
    // selected; the output stage is older than anything still buffered.
    always_comb begin
        fwdHitA  = 1'b0;
        fwdDataA = '0;
        fwdHitB  = 1'b0;
        fwdDataB = '0;
        if (wen_q && (out_addr_q == lookupA)) begin
            fwdHitA  = 1'b1;
            fwdDataA = out_data_q;
        end
        if (wen_q && (out_addr_q == lookupB)) begin
            fwdHitB  = 1'b1;
            fwdDataB = out_data_q;
        end
        for (int i = 0; i < depth; i++) begin
            if ((CW'(i) < count_q) && valid_q[head_q + PW'(i)]) begin
                if (addr_mem[head_q + PW'(i)] == lookupA) begin
                    fwdHitA  = 1'b1;
                    fwdDataA = data_mem[head_q + PW'(i)];
                end
                if (addr_mem[head_q + PW'(i)] == lookupB) begin
                    fwdHitB  = 1'b1;
                    fwdDataB = data_mem[head_q + PW'(i)];
                end
            end
        end
        // x0 is hard-wired zero and never forwarded.
        if (lookupA == '0) begin
            fwdHitA  = 1'b0;
            fwdDataA = '0;
        end
        if (lookupB == '0) begin
            fwdHitB  = 1'b0;
            fwdDataB = '0;
        end
    end
`else
    logic unused_lookup;
    assign unused_lookup = ^{lookupA, lookupB};
    assign fwdHitA  = 1'b0;
    assign fwdHitB  = 1'b0;
    assign fwdDataA = '0;
    assign fwdDataB = '0;
`endif

endmodule

// File: tb/tb_regfile_wb_writer.sv
// tb_regfile_wb_writer
//   Scoreboard bench for regfile_wb_writer. The stimulus process queues every
//   register-file write it expects; a monitor pops and compares on each cycle
//   where regWriteEnable is high. Occupancy, handshake and forwarding values
//   are compared directly by the stimulus process.

module tb_regfile_wb_writer;

    localparam int W  = 32;
    localparam int AW = 5;
    localparam int D  = 4;
    localparam int CW = $clog2(D+1);

`ifdef REGWB_FWD_EN
    localparam bit FWD_ON = 1'b1;
`else
    localparam bit FWD_ON = 1'b0;
`endif

    logic          clock = 1'b0;
    logic          clear = 1'b1;
    logic          aluWbEnable = 1'b0;
    logic [AW-1:0] aluWbAddr = '0;
    logic [W-1:0]  aluWbData = '0;
    logic          pushValid = 1'b0;
    logic          pushReady;
    logic [AW-1:0] pushAddr = '0;
    logic [W-1:0]  pushData = '0;
    logic          regWriteEnable;
    logic [AW-1:0] addrD;
    logic [W-1:0]  dataD;
    logic [AW-1:0] lookupA = '0;
    logic [AW-1:0] lookupB = '0;
    logic          fwdHitA, fwdHitB;
    logic [W-1:0]  fwdDataA, fwdDataB;
    logic [CW-1:0] count;
    logic          empty, full;

    regfile_wb_writer #(.width(W), .addrWidth(AW), .depth(D)) dut (
        .clock          (clock),
        .clear          (clear),
        .aluWbEnable    (aluWbEnable),
        .aluWbAddr      (aluWbAddr),
        .aluWbData      (aluWbData),
        .pushValid      (pushValid),
        .pushReady      (pushReady),
        .pushAddr       (pushAddr),
        .pushData       (pushData),
        .regWriteEnable (regWriteEnable),
        .addrD          (addrD),
        .dataD          (dataD),
        .lookupA        (lookupA),
        .lookupB        (lookupB),
        .fwdHitA        (fwdHitA),
        .fwdHitB        (fwdHitB),
        .fwdDataA       (fwdDataA),
        .fwdDataB       (fwdDataB),
        .count          (count),
        .empty          (empty),
        .full           (full)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [W-1:0]  d;
    } wr_t;

    wr_t exp_q[$];
    int  n_cmp  = 0;
    int  n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic set_alu(input logic en, input logic [AW-1:0] a, input logic [W-1:0] d);
        aluWbEnable = en;
        aluWbAddr   = a;
        aluWbData   = d;
    endtask

    task automatic set_push(input logic v, input logic [AW-1:0] a, input logic [W-1:0] d);
        pushValid = v;
        pushAddr  = a;
        pushData  = d;
    endtask

    task automatic expect_wr(input logic [AW-1:0] a, input logic [W-1:0] d);
        exp_q.push_back('{a: a, d: d});
    endtask

    // Forwarding expectations collapse to zero when the feature is not built.
    task automatic check_fwd_a(input string name, input logic hit, input logic [W-1:0] d);
        check({name, "_hitA"},  32'(fwdHitA),  FWD_ON ? 32'(hit) : 32'd0);
        check({name, "_dataA"}, fwdDataA,      FWD_ON ? d : 32'd0);
    endtask

    task automatic check_fwd_b(input string name, input logic hit, input logic [W-1:0] d);
        check({name, "_hitB"},  32'(fwdHitB),  FWD_ON ? 32'(hit) : 32'd0);
        check({name, "_dataB"}, fwdDataB,      FWD_ON ? d : 32'd0);
    endtask

    // Monitor: every write strobe must match the oldest expected write.
    initial begin
        forever begin
            wr_t e;
            @(negedge clock);
            if (regWriteEnable === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_write: got x%0d=0x%0h, expected no write (t=%0t)",
                             addrD, dataD, $time);
                end else begin
                    e = exp_q.pop_front();
                    check("wr_addr", 32'(addrD), 32'(e.a));
                    check("wr_data", dataD, e.d);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state while clear is held.
        #12;
        check("rst_wen",   32'(regWriteEnable), 32'd0);
        check("rst_addrD", 32'(addrD), 32'd0);
        check("rst_dataD", dataD, 32'd0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_full",  32'(full), 32'd0);
        check("rst_ready", 32'(pushReady), 32'd0);
        clear = 1'b0;

        // Single buffered push with the ALU idle.
        set_push(1'b1, 5'd5, 32'h11);
        lookupA = 5'd5;
        step();
        check("t1_count", 32'(count), 32'd1);
        check_fwd_a("t1_fwd", 1'b1, 32'h11);
        set_push(1'b0, '0, '0);
        expect_wr(5'd5, 32'h11);
        step();
        check("t1_empty", 32'(empty), 32'd1);

        // Fill the buffer while the ALU owns the port every cycle.
        for (int k = 0; k < 4; k++) begin
            set_alu(1'b1, 5'd9, 32'h900 + 32'(k));
            set_push(1'b1, AW'(k + 1), 32'h101 + 32'(k));
            expect_wr(5'd9, 32'h900 + 32'(k));
            step();
            check("t2_count_fill", 32'(count), 32'(k + 1));
        end
        check("t2_full",  32'(full), 32'd1);
        check("t2_ready", 32'(pushReady), 32'd0);
        set_alu(1'b1, 5'd9, 32'h904);
        set_push(1'b1, 5'd6, 32'h106);
        expect_wr(5'd9, 32'h904);
        step();
        check("t2_refused_count", 32'(count), 32'd4);
        set_alu(1'b0, '0, '0);
        set_push(1'b0, '0, '0);
        for (int k = 0; k < 4; k++) expect_wr(AW'(k + 1), 32'h101 + 32'(k));
        for (int k = 0; k < 4; k++) begin
            step();
            check("t2_count_drain", 32'(count), 32'(3 - k));
        end
        check("t2_empty", 32'(empty), 32'd1);

        // WAW squash of an older buffered entry.
        set_push(1'b1, 5'd7, 32'hAA);
        step();
        set_push(1'b0, '0, '0);
        set_alu(1'b1, 5'd7, 32'hBB);
        expect_wr(5'd7, 32'hBB);
        lookupA = 5'd7;
        step();
        check("t3_count_squashed", 32'(count), 32'd1);
        check_fwd_a("t3_fwd_alu", 1'b1, 32'hBB);
        set_alu(1'b0, '0, '0);
        step();
        check("t3_pop_nowrite", 32'(regWriteEnable), 32'd0);
        check("t3_count", 32'(count), 32'd0);
        check_fwd_a("t3_fwd_none", 1'b0, 32'h0);

        // WAW squash of the entry pushed in the same cycle.
        set_alu(1'b1, 5'd12, 32'hC1);
        set_push(1'b1, 5'd12, 32'hC2);
        expect_wr(5'd12, 32'hC1);
        lookupB = 5'd12;
        step();
        check("t3b_count", 32'(count), 32'd1);
        set_alu(1'b0, '0, '0);
        set_push(1'b0, '0, '0);
        check_fwd_b("t3b_fwd", 1'b1, 32'hC1);
        step();
        check("t3b_nowrite", 32'(regWriteEnable), 32'd0);
        check("t3b_count0", 32'(count), 32'd0);

        // Youngest-wins forwarding.
        lookupA = 5'd3;
        lookupB = 5'd20;
        set_alu(1'b1, 5'd20, 32'h201);
        set_push(1'b1, 5'd3, 32'h1);
        expect_wr(5'd20, 32'h201);
        step();
        set_alu(1'b1, 5'd20, 32'h202);
        set_push(1'b1, 5'd3, 32'h2);
        expect_wr(5'd20, 32'h202);
        step();
        check("t4_count2", 32'(count), 32'd2);
        check_fwd_a("t4_fwd_fifo", 1'b1, 32'h2);
        check_fwd_b("t4_fwd_out", 1'b1, 32'h202);
        set_alu(1'b0, '0, '0);
        set_push(1'b0, '0, '0);
        expect_wr(5'd3, 32'h1);
        expect_wr(5'd3, 32'h2);
        step();
        check("t4_count1", 32'(count), 32'd1);
        check_fwd_a("t4_fwd_over_out", 1'b1, 32'h2);
        step();
        check("t4_count0", 32'(count), 32'd0);
        check_fwd_a("t4_fwd_out_last", 1'b1, 32'h2);

        // Writes aimed at x0 are dropped on both paths.
        set_alu(1'b1, 5'd0, 32'h66);
        set_push(1'b1, 5'd0, 32'h55);
        check("t5_ready", 32'(pushReady), 32'd1);
        step();
        set_alu(1'b0, '0, '0);
        set_push(1'b0, '0, '0);
        check("t5_count", 32'(count), 32'd0);
        check("t5_wen", 32'(regWriteEnable), 32'd0);
        check("t5_hold_addr", 32'(addrD), 32'd3);
        check("t5_hold_data", dataD, 32'h2);
        lookupA = 5'd0;
        #1;
        check("t5_x0_hitA", 32'(fwdHitA), 32'd0);
        check("t5_x0_dataA", fwdDataA, 32'd0);

        // Asynchronous clear in the middle of a drain.
        for (int k = 0; k < 3; k++) begin
            set_alu(1'b1, 5'd21, 32'h2100 + 32'(k));
            set_push(1'b1, AW'(10 + k), 32'hA0 + 32'(k));
            expect_wr(5'd21, 32'h2100 + 32'(k));
            step();
        end
        check("t6_count3", 32'(count), 32'd3);
        set_alu(1'b0, '0, '0);
        set_push(1'b0, '0, '0);
        expect_wr(5'd10, 32'hA0);
        step();
        @(negedge clock);
        #1;
        clear = 1'b1;
        #1;
        check("t6_wen",   32'(regWriteEnable), 32'd0);
        check("t6_addrD", 32'(addrD), 32'd0);
        check("t6_dataD", dataD, 32'd0);
        check("t6_count", 32'(count), 32'd0);
        check("t6_ready", 32'(pushReady), 32'd0);
        @(posedge clock);
        #2;
        clear = 1'b0;
        repeat (4) step();
        check("t6_count_after", 32'(count), 32'd0);
        check("t6_empty_after", 32'(empty), 32'd1);

        @(negedge clock);
        #1;
        check("pending_writes", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
